// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter_pkg
// Brief   : Shared definitions for the ALU arbiter slice: alu_control width,
//           one-hot opcode bit positions and arbiter FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  // alu_control is one-hot; each constant is the bit index of one operation
  localparam int c_op_width = 12;
  localparam int c_op_add   = 0;
  localparam int c_op_sub   = 1;
  localparam int c_op_slt   = 2;
  localparam int c_op_sltu  = 3;
  localparam int c_op_and   = 4;
  localparam int c_op_nor   = 5;
  localparam int c_op_or    = 6;
  localparam int c_op_xor   = 7;
  localparam int c_op_sll   = 8;
  localparam int c_op_srl   = 9;
  localparam int c_op_sra   = 10;
  localparam int c_op_lui   = 11;

  // Arbiter sequencing: accept in IDLE, compute in EXEC, hold response in RESP
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module  : alu
// Brief   : Combinational ALU driven by a 12-bit one-hot alu_control.
//           Results wrap at DATA_WIDTH; non-one-hot controls resolve to the
//           lowest set bit (or zero when no bit is set).
// Revision: 1.0 - initial release
// ============================================================================
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_src1,
  input  logic [DATA_WIDTH-1:0] i_src2,
  input  logic [c_op_width-1:0] i_alu_control,
  output logic [DATA_WIDTH-1:0] o_alu_result
);

  localparam int c_sh_w = $clog2(DATA_WIDTH);

  logic [c_sh_w-1:0] w_shamt;
  assign w_shamt = i_src2[c_sh_w-1:0];

  // Select the operation named by the control bit; lui places src2 in the upper half
  always_comb begin
    o_alu_result = '0;
    case (1'b1)
      i_alu_control[c_op_add]:  o_alu_result = i_src1 + i_src2;
      i_alu_control[c_op_sub]:  o_alu_result = i_src1 - i_src2;
      i_alu_control[c_op_slt]:  o_alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(i_src1) < $signed(i_src2)};
      i_alu_control[c_op_sltu]: o_alu_result = {{(DATA_WIDTH-1){1'b0}}, i_src1 < i_src2};
      i_alu_control[c_op_and]:  o_alu_result = i_src1 & i_src2;
      i_alu_control[c_op_nor]:  o_alu_result = ~(i_src1 | i_src2);
      i_alu_control[c_op_or]:   o_alu_result = i_src1 | i_src2;
      i_alu_control[c_op_xor]:  o_alu_result = i_src1 ^ i_src2;
      i_alu_control[c_op_sll]:  o_alu_result = i_src1 << w_shamt;
      i_alu_control[c_op_srl]:  o_alu_result = i_src1 >> w_shamt;
      i_alu_control[c_op_sra]:  o_alu_result = $unsigned($signed(i_src1) >>> w_shamt);
      i_alu_control[c_op_lui]:  o_alu_result = i_src2 << (DATA_WIDTH / 2);
      default:                  o_alu_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Two-way round-robin grant logic. Remembers which requester won
//           the last accepted transfer; on a tie the other one wins.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  // Reset to 1 so that requester 0 wins the first tie
  logic r_last_grant;

  // Tie goes to the requester that did not win last; a lone request always wins
  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = r_last_grant ? 2'b01 : 2'b10;
    end
  end

  // History advances only when the grant is actually consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Brief   : Shares one ALU between two valid/ready requesters using
//           round-robin arbitration. IDLE -> EXEC -> RESP sequencing with a
//           registered, id-tagged response. Optional statistics counters
//           are enabled by defining ALU_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = c_op_width
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_src1,
  input  logic [DATA_WIDTH-1:0] req0_src2,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_src1,
  input  logic [DATA_WIDTH-1:0] req1_src2,
  input  logic [OP_WIDTH-1:0]   req1_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_err,
  output logic                  busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1,
  output logic [15:0]           err_cnt
`endif
);

  arb_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_src1;
  logic [DATA_WIDTH-1:0] r_src2;
  logic [OP_WIDTH-1:0]   r_op;
  logic                  r_id;
  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_result;
  logic                  r_rsp_err;
  logic                  r_busy;

  logic [1:0]            w_grant;
  logic                  w_accept;
  logic                  w_op_ok;
  logic [DATA_WIDTH-1:0] w_alu_result;

  // Accept only from IDLE; ready depends on valid and state, never on rsp_ready
  assign w_accept   = (r_state == ST_IDLE) && !reset && (w_grant != 2'b00);
  assign req0_ready = w_accept && w_grant[0];
  assign req1_ready = w_accept && w_grant[1];

  // Exactly one bit set; an all-zero opcode is also an error
  assign w_op_ok = (r_op != '0) && ((r_op & (r_op - OP_WIDTH'(1))) == '0);

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;
  assign busy       = r_busy;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (reset),
    .i_valid  ({req1_valid, req0_valid}),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_src1        (r_src1),
    .i_src2        (r_src2),
    .i_alu_control (r_op),
    .o_alu_result  (w_alu_result)
  );

  // Sequencer: latch granted operands, capture ALU result, hold until consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_src1       <= '0;
      r_src2       <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_src1  <= w_grant[1] ? req1_src1 : req0_src1;
            r_src2  <= w_grant[1] ? req1_src2 : req0_src2;
            r_op    <= w_grant[1] ? req1_op   : req0_op;
            r_id    <= w_grant[1];
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_result <= w_op_ok ? w_alu_result : '0;
          r_rsp_err    <= !w_op_ok;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;
  logic [15:0] r_err_cnt;
  logic        w_rsp_fire;

  assign w_rsp_fire = r_rsp_valid && rsp_ready;

  // Saturating per-requester accept counts and delivered-error count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (req0_ready && (r_grant_cnt0 != 16'hFFFF)) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (req1_ready && (r_grant_cnt1 != 16'hFFFF)) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
      if (w_rsp_fire && r_rsp_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
  assign err_cnt    = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_arbiter
// Brief   : Directed-vector bench for alu_arbiter. Accepted requests push
//           their hand-computed response into a scoreboard queue; a monitor
//           pops and compares on every response handshake.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_src1, req0_src2, req1_src1, req1_src2;
  logic [11:0] req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [7:0]  rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, err_cnt;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(8), .OP_WIDTH(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_src1  (req0_src1),
    .req0_src2  (req0_src2),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_src1  (req1_src1),
    .req1_src2  (req1_src2),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .err_cnt    (err_cnt)
`endif
  );

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         acc_id[$];
  int         acc_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         push_en = 1'b1;
  logic [7:0] exp_res0, exp_res1;
  logic       exp_err0, exp_err1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept watcher: log every grant and queue the expected response
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_ready || req1_ready) chk("single_grant", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (req0_ready) begin
        acc_id.push_back(0);
        acc_cyc.push_back(cyc);
        if (push_en) sb.push_back('{1'b0, exp_res0, exp_err0, cyc + 2});
      end
      if (req1_ready) begin
        acc_id.push_back(1);
        acc_cyc.push_back(cyc);
        if (push_en) sb.push_back('{1'b1, exp_res1, exp_err1, cyc + 2});
      end
    end
  end

  // Response monitor: compare each handshake with the oldest expectation
  logic prev_v = 1'b0;
  int   first_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid && !prev_v) first_cyc = cyc;
    prev_v = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: id %0d result %0h arrived, nothing expected", rsp_id, rsp_result);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        chk("rsp_result", {24'd0, rsp_result}, {24'd0, e.res});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_latency", first_cyc, e.cyc);
      end
    end
  end

  task automatic set_req(input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [11:0] op, input logic [7:0] er, input logic ee);
    if (id) begin
      req1_src1 = a; req1_src2 = b; req1_op = op; exp_res1 = er; exp_err1 = ee; req1_valid = 1'b1;
    end else begin
      req0_src1 = a; req0_src2 = b; req0_op = op; exp_res0 = er; exp_err0 = ee; req0_valid = 1'b1;
    end
  endtask

  // Wait for the requester's ready, then drop its valid after the accept edge
  task automatic wait_accept(input bit id);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: requester %0d never got ready", id);
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy %0d rsp_valid %0d", busy, rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    bit ok;
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_src1 = '0; req0_src2 = '0; req0_op = '0;
    req1_src1 = '0; req1_src2 = '0; req1_op = '0;
    exp_res0 = '0; exp_res1 = '0; exp_err0 = 1'b0; exp_err1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; reset = 1'b0;

    // Basic ops; requester 1 goes last so the tie test starts with requester 0
    set_req(0, 8'h05, 8'h03, 12'h001, 8'h08, 1'b0); wait_accept(0);
    set_req(0, 8'h12, 8'h34, 12'h000, 8'h00, 1'b1); wait_accept(0);
    set_req(0, 8'h12, 8'h34, 12'h003, 8'h00, 1'b1); wait_accept(0);
    set_req(1, 8'h03, 8'h05, 12'h002, 8'hFE, 1'b0); wait_accept(1);
    set_req(1, 8'hFF, 8'h01, 12'h001, 8'h00, 1'b0); wait_accept(1);

    // Both requesters valid continuously: alternating grants 3 cycles apart
    wait_idle();
    n0 = acc_id.size();
    set_req(0, 8'h0F, 8'h3C, 12'h010, 8'h0C, 1'b0);
    set_req(1, 8'h0F, 8'hFF, 12'h080, 8'hF0, 1'b0);
    for (int i = 0; i < 40 && acc_id.size() < n0 + 4; i++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (acc_id.size() < n0 + 4) begin
      checks++; errors++;
      $display("FAIL rr_timeout: %0d accepts seen, 4 required", acc_id.size() - n0);
    end else begin
      for (int k = 0; k < 4; k++) chk("rr_order", acc_id[n0 + k], k % 2);
      for (int k = 1; k < 4; k++) chk("rr_spacing", acc_cyc[n0 + k] - acc_cyc[n0 + k - 1], 3);
    end

    // Response back-pressure: outputs stable and no accepts while held
    wait_idle();
    rsp_ready = 1'b0;
    set_req(0, 8'h50, 8'h0A, 12'h040, 8'h5A, 1'b0); wait_accept(0);
    set_req(1, 8'h10, 8'h01, 12'h002, 8'h0F, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    chk("stall_rsp_seen", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_result", {24'd0, rsp_result}, 32'h5A);
      chk("stall_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("stall_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_accept(1);

`ifdef ALU_ARB_STATS_EN
    wait_idle();
    chk("err_cnt", {16'd0, err_cnt}, 32'd2);
`endif

    // Reset during EXEC discards the op; first tie afterwards goes to req0
    wait_idle();
    push_en = 1'b0;
    set_req(0, 8'h01, 8'h01, 12'h001, 8'h02, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req0_ready) begin ok = 1'b1; break; end
    end
    chk("kill_accept_seen", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; req0_valid = 1'b0;
    @(negedge clk);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("kill_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("kill_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; push_en = 1'b1;
    n0 = acc_id.size();
    set_req(0, 8'h20, 8'h22, 12'h001, 8'h42, 1'b0);
    set_req(1, 8'h01, 8'h03, 12'h100, 8'h08, 1'b0);
    for (int i = 0; i < 10 && acc_id.size() <= n0; i++) @(negedge clk);
    @(posedge clk); #1 req0_valid = 1'b0;
    if (acc_id.size() <= n0) begin
      checks++; errors++;
      $display("FAIL post_reset_timeout: no accept after reset");
    end else begin
      chk("post_reset_tie", acc_id[n0], 0);
    end
    wait_accept(1);

    wait_idle();
    chk("sb_drained", sb.size(), 0);
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", {16'd0, grant_cnt0}, 32'd1);
    chk("grant_cnt1", {16'd0, grant_cnt1}, 32'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
